debounce_toggle_multi: RTL and testbench
========================================

# debounce_toggle_multi

Parametrised, multi-channel successor to the single-button debounce/toggle block. For each of `N_CH` raw push-button inputs sampled on the 1 kHz tick clock, it provides:

- a synchronised, debounced level;
- a toggle state;
- single-cycle press and release strobes;
- a single-cycle long-press strobe.

It sits between the board buttons and the mode/control logic of the lab top level, and replaces per-button debounce instances.

## Interface
Parameters:
- `N_CH`, 4, number of independent button channels.
- `STABLE_CNT`, 20, consecutive disagreeing samples required before the debounced level changes (20 ms at 1 kHz); legal range 2..65535.
- `LONG_CNT`, 1000, cycles the debounced level must stay high after a press before `BTN_LONG` fires; must be greater than `STABLE_CNT`.
- `ACTIVE_LOW`, 0, when set to 1, raw inputs are inverted before synchronisation (a pressed button reads 0).

Ports:
- `CLK_1KHZ` in 1: sampling clock; all logic is on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `BTN_RAW` in `N_CH`: raw, bouncing, asynchronous button inputs.
- `CLR_TOGGLE` in `N_CH`: synchronous per-channel clear of `BTN_TOGGLE`.
- `BTN_LEVEL` out `N_CH`: debounced level (1 = pressed).
- `BTN_TOGGLE` out `N_CH`: flips on each debounced press.
- `BTN_PRESS` out `N_CH`: 1-cycle strobe on each debounced 0→1 transition.
- `BTN_RELEASE` out `N_CH`: 1-cycle strobe on each debounced 1→0 transition.
- `BTN_LONG` out `N_CH`: 1-cycle strobe, at most once per press, when the hold time reaches `LONG_CNT`.

## Operation
- Channels are fully independent and identical. Nothing is shared except clock and reset.
- Input path per channel: optional inversion (`ACTIVE_LOW`), then a 2-flop synchroniser (`s1`, `s2`).
- Debounce counter `cnt` (width `$clog2(STABLE_CNT)`):
  - if `s2` equals `BTN_LEVEL`: `cnt` is set to 0;
  - else if `cnt` equals `STABLE_CNT-1`: `BTN_LEVEL` is set to `s2` and `cnt` is set to 0;
  - else `cnt` increments.
- Any single sample agreeing with the current level restarts the count, so a bounce shorter than `STABLE_CNT` samples produces no output change.
- Per-channel FSM:
  - States: `RELEASED`, `PRESSED`, `LONG_HELD`.
  - `RELEASED` → `PRESSED` on the debounced rise. `BTN_PRESS` pulses, `BTN_TOGGLE` flips, `hold` is set to 0.
  - `PRESSED`: `hold` increments each cycle. When `hold` equals `LONG_CNT-1`, the FSM moves to `LONG_HELD` and `BTN_LONG` pulses.
  - `PRESSED` or `LONG_HELD` → `RELEASED` on the debounced fall. `BTN_RELEASE` pulses.
  - `LONG_HELD` does not re-fire `BTN_LONG`.
- `hold` width is `$clog2(LONG_CNT)` and saturates, with no wrap-around.
- `CLR_TOGGLE[i]` forces `BTN_TOGGLE[i]` to 0 on the next edge. If it coincides with a press on the same edge, the clear wins and toggle = 0.

## Timing
- Reset state (asynchronous, while `RST_N`=0):
  - `s1`, `s2`, `cnt`, `hold` = 0; FSM = `RELEASED`;
  - all outputs = 0.
  - With `ACTIVE_LOW`=1 the reset value still means "released", because inversion happens before `s1`.
- Press latency: the raw input becomes stable before rising edge k. `BTN_LEVEL`, `BTN_PRESS` and the `BTN_TOGGLE` flip all appear after edge k+1+`STABLE_CNT`. Release latency is the same.
- `BTN_PRESS`, `BTN_RELEASE` and `BTN_LONG` are registered, high for exactly one cycle, and never asserted together on one channel.
- `BTN_LONG` asserts `LONG_CNT` cycles after the `BTN_PRESS` cycle, if the level is still high.
- A release on the same edge that `hold` would reach `LONG_CNT-1`: release wins and `BTN_LONG` does not fire.
- Reset asserted mid-count or mid-hold clears everything immediately. No strobe is emitted when reset is released while the button is held: after release of reset, the level rises only via a fresh `STABLE_CNT` qualification, which produces a `BTN_PRESS` then.

## Structure
- A shared package, `debounce_pkg`, holds:
  - the FSM state typedef (`RELEASED`, `PRESSED`, `LONG_HELD`);
  - the width helper constants.
- Sub-module `debounce_channel` contains one channel: synchroniser, counter, FSM and toggle. The top level is a generate loop over `N_CH` instances plus the `ACTIVE_LOW` inversion.

## Test plan
All scenarios use `N_CH`=2, `STABLE_CNT`=3, `LONG_CNT`=8.
- Reset, then idle with raw = 0 → all outputs 0 for 20 cycles.
- Ch0 raw pulses high for 2 cycles, then low (bounce) → no `BTN_LEVEL` change and no strobes.
- Ch0 raw goes high before edge k and is held → `BTN_LEVEL`[0]=1, `BTN_PRESS`[0] is a single-cycle pulse, and `BTN_TOGGLE`[0]=1, all after edge k+4. Ch1 is unaffected.
- Ch0 is held 12 cycles past the press → a single `BTN_LONG`[0] pulse 8 cycles after `BTN_PRESS`. On release: `BTN_RELEASE`[0] pulses, `BTN_TOGGLE`[0] stays 1.
- A second ch0 press with `CLR_TOGGLE`[0] asserted on the press edge → `BTN_TOGGLE`[0]=0 and `BTN_PRESS`[0] still pulses.
- `RST_N` driven low while ch1 is mid-hold → all outputs 0 asynchronously. After release of reset with raw still high, `BTN_PRESS`[1] fires 4 cycles later.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the multi-channel button debouncer.
// Holds the per-channel press FSM encoding and default timing constants.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_t;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_STABLE_CNT = 20;
  localparam int DEF_LONG_CNT   = 1000;

  // Counter width for a terminal value of n-1; never narrower than one bit.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_toggle_multi_if.sv
// Button bundle between board pins and control logic: raw inputs and clears in,
// debounced level, toggle and strobes out, plus per-channel FSM state for debug.
interface debounce_toggle_multi_if #(
    parameter int N_CH = 4
);
    import debounce_pkg::*;

    logic [N_CH-1:0] BTN_RAW;
    logic [N_CH-1:0] CLR_TOGGLE;
    logic [N_CH-1:0] BTN_LEVEL;
    logic [N_CH-1:0] BTN_TOGGLE;
    logic [N_CH-1:0] BTN_PRESS;
    logic [N_CH-1:0] BTN_RELEASE;
    logic [N_CH-1:0] BTN_LONG;
    btn_state_t [N_CH-1:0] fsm_state;

    modport master (
        output BTN_RAW, CLR_TOGGLE,
        input  BTN_LEVEL, BTN_TOGGLE, BTN_PRESS, BTN_RELEASE, BTN_LONG, fsm_state
    );

    modport slave (
        input  BTN_RAW, CLR_TOGGLE,
        output BTN_LEVEL, BTN_TOGGLE, BTN_PRESS, BTN_RELEASE, BTN_LONG, fsm_state
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, press/long FSM
// and toggle flop. All strobes are registered and mutually exclusive.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT = 20,
    parameter int LONG_CNT   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    input  logic       clr_toggle,
    output logic       level,
    output logic       toggle,
    output logic       press_strb,
    output logic       release_strb,
    output logic       long_strb,
    output btn_state_t state
);

    localparam int CW = width_of(STABLE_CNT);
    localparam int HW = width_of(LONG_CNT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold, hold_n, hold_inc;
    logic          level_n, rise, fall;
    logic          toggle_n, press_n, release_n, long_n;
    btn_state_t    state_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            cnt          <= '0;
            level        <= 1'b0;
            hold         <= '0;
            state        <= RELEASED;
            toggle       <= 1'b0;
            press_strb   <= 1'b0;
            release_strb <= 1'b0;
            long_strb    <= 1'b0;
        end else begin
            s1           <= raw;
            s2           <= s1;
            cnt          <= cnt_n;
            level        <= level_n;
            hold         <= hold_n;
            state        <= state_n;
            toggle       <= toggle_n;
            press_strb   <= press_n;
            release_strb <= release_n;
            long_strb    <= long_n;
        end
    end

    // The FSM reacts to the level change on the same edge it is committed,
    // so strobes line up with the new debounced level.
    always_comb begin
        cnt_n   = cnt;
        level_n = level;
        if (s2 == level) begin
            cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
            level_n = s2;
            cnt_n   = '0;
        end else begin
            cnt_n = cnt + CW'(1);
        end
        rise = level_n & ~level;
        fall = ~level_n & level;
    end

    always_comb begin
        hold_inc  = (hold == '1) ? hold : hold + HW'(1);
        state_n   = state;
        hold_n    = hold;
        toggle_n  = toggle;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        case (state)
            RELEASED: begin
                if (rise) begin
                    state_n  = PRESSED;
                    press_n  = 1'b1;
                    toggle_n = ~toggle;
                    hold_n   = '0;
                end
            end
            PRESSED: begin
                // A fall on the long-press edge takes priority over the long strobe.
                if (fall) begin
                    state_n   = RELEASED;
                    release_n = 1'b1;
                end else if (hold == HOLD_LAST) begin
                    state_n = LONG_HELD;
                    long_n  = 1'b1;
                    hold_n  = hold_inc;
                end else begin
                    hold_n = hold_inc;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_n   = RELEASED;
                    release_n = 1'b1;
                end else begin
                    hold_n = hold_inc;
                end
            end
            default: state_n = RELEASED;
        endcase
        if (clr_toggle) toggle_n = 1'b0;
    end

endmodule

// File: rtl/debounce_toggle_multi.sv
// N_CH independent debounce/toggle channels with optional input inversion
// for active-low buttons; inversion precedes the synchroniser.
module debounce_toggle_multi
    import debounce_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int LONG_CNT   = DEF_LONG_CNT,
    parameter int ACTIVE_LOW = 0
) (
    input logic CLK_1KHZ,
    input logic RST_N,
    debounce_toggle_multi_if.slave btn
);

    logic [N_CH-1:0] raw_pol;
    logic [N_CH-1:0] level_vec, toggle_vec, press_vec, release_vec, long_vec;
    btn_state_t [N_CH-1:0] state_vec;

    assign raw_pol = (ACTIVE_LOW != 0) ? ~btn.BTN_RAW : btn.BTN_RAW;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT(STABLE_CNT),
            .LONG_CNT  (LONG_CNT)
        ) u_ch (
            .clk         (CLK_1KHZ),
            .rst_n       (RST_N),
            .raw         (raw_pol[i]),
            .clr_toggle  (btn.CLR_TOGGLE[i]),
            .level       (level_vec[i]),
            .toggle      (toggle_vec[i]),
            .press_strb  (press_vec[i]),
            .release_strb(release_vec[i]),
            .long_strb   (long_vec[i]),
            .state       (state_vec[i])
        );
    end

    assign btn.BTN_LEVEL   = level_vec;
    assign btn.BTN_TOGGLE  = toggle_vec;
    assign btn.BTN_PRESS   = press_vec;
    assign btn.BTN_RELEASE = release_vec;
    assign btn.BTN_LONG    = long_vec;
    assign btn.fsm_state   = state_vec;

endmodule

// File: tb/tb_debounce_toggle_multi.sv
// Directed bench for debounce_toggle_multi (2 channels, STABLE_CNT=3, LONG_CNT=8)
// plus a single-channel active-low instance.
module tb_debounce_toggle_multi;
  import debounce_pkg::*;

  localparam int N_CH = 2;
  localparam int STABLE_CNT = 3;
  localparam int LONG_CNT = 8;

  typedef struct {
    logic [1:0] raw;
    logic [1:0] clr;
    logic [1:0] level;
    logic [1:0] tog;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[$];

  debounce_toggle_multi_if #(.N_CH(N_CH)) bif ();
  debounce_toggle_multi_if #(.N_CH(1)) aif ();

  debounce_toggle_multi #(
    .N_CH(N_CH), .STABLE_CNT(STABLE_CNT), .LONG_CNT(LONG_CNT), .ACTIVE_LOW(0)
  ) dut (
    .CLK_1KHZ(clk), .RST_N(rst_n), .btn(bif)
  );

  debounce_toggle_multi #(
    .N_CH(1), .STABLE_CNT(STABLE_CNT), .LONG_CNT(LONG_CNT), .ACTIVE_LOW(1)
  ) dut_al (
    .CLK_1KHZ(clk), .RST_N(rst_n), .btn(aif)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] raw, input logic [1:0] clr, input logic [1:0] level,
                         input logic [1:0] tog, input logic [1:0] prs, input logic [1:0] rel,
                         input logic [1:0] lng, input int n);
    vec_t v;
    v.raw = raw; v.clr = clr; v.level = level; v.tog = tog;
    v.prs = prs; v.rel = rel; v.lng = lng;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string name, input int idx);
    check({name, "_level"}, idx, {2'b00, bif.BTN_LEVEL}, 4'd0);
    check({name, "_toggle"}, idx, {2'b00, bif.BTN_TOGGLE}, 4'd0);
    check({name, "_press"}, idx, {2'b00, bif.BTN_PRESS}, 4'd0);
    check({name, "_release"}, idx, {2'b00, bif.BTN_RELEASE}, 4'd0);
    check({name, "_long"}, idx, {2'b00, bif.BTN_LONG}, 4'd0);
  endtask

  initial begin
    logic seen;
    int first;

    bif.BTN_RAW = '0;
    bif.CLR_TOGGLE = '0;
    aif.BTN_RAW = 1'b1;
    aif.CLR_TOGGLE = 1'b0;

    // reset state
    repeat (2) step();
    check_all_zero("reset", 0);
    check("reset_state0", 0, {2'b00, bif.fsm_state[0]}, {2'b00, RELEASED});
    check("reset_al_level", 0, {3'b000, aif.BTN_LEVEL}, 4'd0);
    rst_n = 1'b1;

    // raw, clr, level, toggle, press, release, long, count
    add_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 20);  // idle
    add_vec(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);   // 2-sample bounce
    add_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 6);
    add_vec(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4);   // press qualifying
    add_vec(2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);   // press at k+4
    add_vec(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 7);
    add_vec(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1);   // long 8 after press
    add_vec(2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 3);
    add_vec(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 4);   // release qualifying
    add_vec(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 1);   // release strobe
    add_vec(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    add_vec(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 4);   // second press
    add_vec(2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 1);   // clear wins over flip
    add_vec(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4);
    add_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add_vec(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4);   // third press
    add_vec(2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add_vec(2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1);   // standalone clear
    add_vec(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4);
    add_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add_vec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      bif.BTN_RAW = vecs[i].raw;
      bif.CLR_TOGGLE = vecs[i].clr;
      step();
      check("tbl_level", i, {2'b00, bif.BTN_LEVEL}, {2'b00, vecs[i].level});
      check("tbl_toggle", i, {2'b00, bif.BTN_TOGGLE}, {2'b00, vecs[i].tog});
      check("tbl_press", i, {2'b00, bif.BTN_PRESS}, {2'b00, vecs[i].prs});
      check("tbl_release", i, {2'b00, bif.BTN_RELEASE}, {2'b00, vecs[i].rel});
      check("tbl_long", i, {2'b00, bif.BTN_LONG}, {2'b00, vecs[i].lng});
    end
    bif.CLR_TOGGLE = '0;
    check("al_idle_level", 0, {3'b000, aif.BTN_LEVEL}, 4'd0);

    // release lands on the edge the long strobe would fire: release wins
    bif.BTN_RAW = 2'b01;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (bif.BTN_PRESS[0]) seen = 1'b1;
    end
    check("bnd_press_seen", 0, {3'b000, seen}, 4'd1);
    repeat (3) step();
    bif.BTN_RAW = 2'b00;
    for (int c = 4; c <= 8; c++) begin
      step();
      check("bnd_long", c, {2'b00, bif.BTN_LONG}, 4'd0);
      check("bnd_release", c, {2'b00, bif.BTN_RELEASE}, (c == 8) ? 4'd1 : 4'd0);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      check("bnd_after_long", c, {2'b00, bif.BTN_LONG}, 4'd0);
      check("bnd_after_level", c, {2'b00, bif.BTN_LEVEL}, 4'd0);
    end

    // asynchronous reset while ch1 is mid-hold, then fresh qualification
    bif.BTN_RAW = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (bif.BTN_PRESS[1]) seen = 1'b1;
    end
    check("rst_press_seen", 0, {3'b000, seen}, 4'd1);
    repeat (3) step();
    check("rst_pre_state1", 0, {2'b00, bif.fsm_state[1]}, {2'b00, PRESSED});
    check("rst_pre_level", 0, {2'b00, bif.BTN_LEVEL}, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async", 0);
    check("rst_async_state1", 0, {2'b00, bif.fsm_state[1]}, {2'b00, RELEASED});
    step();
    step();
    check_all_zero("rst_held", 0);
    rst_n = 1'b1;
    first = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bif.BTN_PRESS[1] && first == 0) first = c;
      check("rst_ch0_press", c, {2'b00, bif.BTN_PRESS & 2'b01}, 4'd0);
    end
    check("rst_press_edge", 0, 4'(first), 4'(STABLE_CNT + 2));
    check("rst_toggle", 0, {2'b00, bif.BTN_TOGGLE}, 4'd2);
    check("rst_level", 0, {2'b00, bif.BTN_LEVEL}, 4'd2);

    // active-low channel: driving the pin low is a press
    aif.BTN_RAW = 1'b0;
    for (int c = 1; c <= STABLE_CNT + 2; c++) begin
      step();
      check("al_level", c, {3'b000, aif.BTN_LEVEL}, (c == STABLE_CNT + 2) ? 4'd1 : 4'd0);
    end
    check("al_toggle", 0, {3'b000, aif.BTN_TOGGLE}, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
